// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package pipe_pkg;

    // Register-number width carried in the shadow destination records.
    localparam int unsigned STAGE_RN_W = 5;

    // Operand forward select encoding.
    localparam logic [1:0] FWD_REG  = 2'b00;  // register file
    localparam logic [1:0] FWD_EXE  = 2'b01;  // EX-stage ALU result
    localparam logic [1:0] FWD_MEM  = 2'b10;  // MEM-stage ALU result
    localparam logic [1:0] FWD_LOAD = 2'b11;  // MEM-stage load data

    // Destination info that travels down the pipe with each instruction.
    typedef struct packed {
        logic                  wreg;
        logic                  m2reg;
        logic [STAGE_RN_W-1:0] rn;
    } stage_dst_t;

    // A bubble writes nothing, so it can never be matched by a consumer.
    localparam stage_dst_t STAGE_BUBBLE = '{wreg: 1'b0, m2reg: 1'b0, rn: '0};

    // True when a stage will write register src; $0 is hardwired and never matches.
    function automatic logic dst_hit(stage_dst_t dst, logic [STAGE_RN_W-1:0] src);
        return dst.wreg && (dst.rn == src) && (src != '0);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forward-select decision for one source operand against the EX and MEM shadows.
module pipe_fwd_sel
    import pipe_pkg::*;
(
    input  logic [STAGE_RN_W-1:0] src,
    input  logic                  en,
    input  stage_dst_t            ex_dst,
    input  stage_dst_t            mem_dst,
    output logic [1:0]            sel,
    output logic                  load_hit
);

    logic hit_e;
    logic hit_m;

    assign hit_e = en && dst_hit(ex_dst, src);
    assign hit_m = en && dst_hit(mem_dst, src);

    // EX wins over MEM; a load in EX cannot forward yet and is flagged instead.
    always_comb begin
        sel      = FWD_REG;
        load_hit = 1'b0;
        if (hit_e && ex_dst.m2reg) begin
            // Select is don't-care during the stall; leave it at the regfile.
            load_hit = 1'b1;
        end else if (hit_e) begin
            sel = FWD_EXE;
        end else if (hit_m) begin
            sel = mem_dst.m2reg ? FWD_LOAD : FWD_MEM;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Data-hazard unit beside the ID stage: forward selects, load-use stall, event counters.
// WB needs no shadow here: the register file writes on the falling edge, so ID
// already reads the value being retired.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned RN_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [RN_W-1:0]  id_rs,
    input  logic [RN_W-1:0]  id_rt,
    input  logic [RN_W-1:0]  id_rn,
    input  logic             id_rs1isreg,
    input  logic             id_rs2isreg,
    input  logic             id_isstore,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             btaken,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [1:0]       fwdst,
    output logic             exe_load,
    output logic             wpcir,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    stage_dst_t ex_q;
    stage_dst_t ex_d;
    stage_dst_t mem_q;

    logic load_a;
    logic load_b;
    logic load_st;
    logic fwd_event;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_d;

    // Operand a reads rs.
    pipe_fwd_sel u_sel_a (
        .src      (id_rs),
        .en       (id_rs1isreg),
        .ex_dst   (ex_q),
        .mem_dst  (mem_q),
        .sel      (fwda),
        .load_hit (load_a)
    );

    // Operand b reads rt when the second ALU input is a register.
    pipe_fwd_sel u_sel_b (
        .src      (id_rt),
        .en       (id_rs2isreg),
        .ex_dst   (ex_q),
        .mem_dst  (mem_q),
        .sel      (fwdb),
        .load_hit (load_b)
    );

    // Store data also reads rt, independently of operand b.
    pipe_fwd_sel u_sel_st (
        .src      (id_rt),
        .en       (id_isstore),
        .ex_dst   (ex_q),
        .mem_dst  (mem_q),
        .sel      (fwdst),
        .load_hit (load_st)
    );

    assign exe_load  = load_a | load_b | load_st;
    assign wpcir     = ~exe_load;
    assign fwd_event = ~exe_load &
                       ((fwda != FWD_REG) | (fwdb != FWD_REG) | (fwdst != FWD_REG));

    // Next EX record: a stalled (or branch-killed) ID instruction enters as a bubble.
    always_comb begin
        ex_d = STAGE_BUBBLE;
        // btaken gating is redundant with the decoder but keeps a killed slot harmless.
        if (!exe_load && !btaken) begin
            ex_d.wreg  = id_wreg;
            ex_d.m2reg = id_m2reg;
            ex_d.rn    = id_rn;
        end
    end

    // Shadow pipeline EX -> MEM.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ex_q  <= STAGE_BUBBLE;
            mem_q <= STAGE_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
        end
    end

    // Saturating event counters: hold once all ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (exe_load && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (fwd_event && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 1'b1;
        end
    end

    // Counter state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed program fragments plus random
// traffic against a nearest-producer reference model.
module tb_pipe_hazard_unit;

    localparam int SMALL_W   = 6;
    localparam int SMALL_MAX = (1 << SMALL_W) - 1;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  id_rs, id_rt, id_rn;
    logic        id_rs1isreg, id_rs2isreg, id_isstore, id_wreg, id_m2reg, btaken;

    logic [1:0]  fwda, fwdb, fwdst;
    logic        exe_load, wpcir;
    logic [15:0] stall_cnt, fwd_cnt;

    logic [1:0]         fwda_s, fwdb_s, fwdst_s;
    logic               exe_load_s, wpcir_s;
    logic [SMALL_W-1:0] stall_cnt_s, fwd_cnt_s;

    pipe_hazard_unit dut (
        .clock(clock), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_rn(id_rn),
        .id_rs1isreg(id_rs1isreg), .id_rs2isreg(id_rs2isreg), .id_isstore(id_isstore),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .btaken(btaken),
        .fwda(fwda), .fwdb(fwdb), .fwdst(fwdst),
        .exe_load(exe_load), .wpcir(wpcir),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    pipe_hazard_unit #(.CNT_W(SMALL_W)) dut_s (
        .clock(clock), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_rn(id_rn),
        .id_rs1isreg(id_rs1isreg), .id_rs2isreg(id_rs2isreg), .id_isstore(id_isstore),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .btaken(btaken),
        .fwda(fwda_s), .fwdb(fwdb_s), .fwdst(fwdst_s),
        .exe_load(exe_load_s), .wpcir(wpcir_s),
        .stall_cnt(stall_cnt_s), .fwd_cnt(fwd_cnt_s)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: instructions in flight, newest first ([0]=one ahead, [1]=two ahead).
    typedef struct {
        bit wr;
        bit ld;
        int rn;
    } instr_t;
    instr_t flight[$];
    int     exp_stall;
    int     exp_fwd;

    // Values seen at the last sample point, for directed checks.
    logic [1:0]  obs_fwda, obs_fwdb, obs_fwdst;
    logic        obs_exe_load, obs_wpcir;
    logic [15:0] obs_stall_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic instr_t bubble();
        instr_t b;
        b.wr = 0; b.ld = 0; b.rn = 0;
        return b;
    endfunction

    task automatic reset_model();
        flight = {};
        flight.push_back(bubble());
        flight.push_back(bubble());
        exp_stall = 0;
        exp_fwd   = 0;
    endtask

    // Nearest in-flight producer of src decides: adjacent ALU -> 1, adjacent load -> stall,
    // two ahead -> 2 (ALU) or 3 (load), none -> 0.
    function automatic int ref_sel(input int src, input bit en, output bit stall);
        stall = 0;
        if (!en || src == 0) return 0;
        for (int d = 0; d < 2; d++) begin
            if (flight[d].wr && flight[d].rn == src) begin
                if (d == 0) begin
                    if (flight[d].ld) begin
                        stall = 1;
                        return 0;
                    end
                    return 1;
                end
                return flight[d].ld ? 3 : 2;
            end
        end
        return 0;
    endfunction

    task automatic set_id(input int rs, input int rt, input int rn, input bit r1, input bit r2,
                          input bit st, input bit wr, input bit m2, input bit bt);
        id_rs = 5'(rs); id_rt = 5'(rt); id_rn = 5'(rn);
        id_rs1isreg = r1; id_rs2isreg = r2; id_isstore = st;
        id_wreg = wr; id_m2reg = m2; btaken = bt;
    endtask

    // One clock with the current ID inputs: predict, sample at negedge, then advance model.
    task automatic step();
        bit sa, sb, ss, stall;
        int ea, eb, es;
        int min_s;
        ea = ref_sel(int'(id_rs), id_rs1isreg, sa);
        eb = ref_sel(int'(id_rt), id_rs2isreg, sb);
        es = ref_sel(int'(id_rt), id_isstore, ss);
        stall = sa | sb | ss;
        @(negedge clock);
        obs_fwda = fwda; obs_fwdb = fwdb; obs_fwdst = fwdst;
        obs_exe_load = exe_load; obs_wpcir = wpcir; obs_stall_cnt = stall_cnt;
        chk("exe_load", int'(exe_load), int'(stall));
        chk("wpcir", int'(wpcir), int'(!stall));
        chk("exe_load_s", int'(exe_load_s), int'(stall));
        if (!stall) begin
            chk("fwda", int'(fwda), ea);
            chk("fwdb", int'(fwdb), eb);
            chk("fwdst", int'(fwdst), es);
            chk("fwdst_s", int'(fwdst_s), es);
        end
        chk("stall_cnt", int'(stall_cnt), exp_stall);
        chk("fwd_cnt", int'(fwd_cnt), exp_fwd);
        min_s = (exp_stall > SMALL_MAX) ? SMALL_MAX : exp_stall;
        chk("stall_cnt_s", int'(stall_cnt_s), min_s);
        min_s = (exp_fwd > SMALL_MAX) ? SMALL_MAX : exp_fwd;
        chk("fwd_cnt_s", int'(fwd_cnt_s), min_s);
        @(posedge clock);
        if (stall) begin
            if (exp_stall < 16'hFFFF) exp_stall++;
        end else if (ea != 0 || eb != 0 || es != 0) begin
            if (exp_fwd < 16'hFFFF) exp_fwd++;
        end
        if (stall || btaken) begin
            flight.push_front(bubble());
        end else begin
            instr_t n;
            n.wr = id_wreg; n.ld = id_m2reg; n.rn = int'(id_rn);
            flight.push_front(n);
        end
        void'(flight.pop_back());
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_model();

        // Reset held with random ID traffic: everything quiet.
        for (int i = 0; i < 4; i++) begin
            set_id($urandom_range(3), $urandom_range(3), $urandom_range(3), 1, 1, 1, 1,
                   1'($urandom), 0);
            @(posedge clock);
            @(negedge clock);
            chk("rst_fwda", int'(fwda), 0);
            chk("rst_fwdb", int'(fwdb), 0);
            chk("rst_fwdst", int'(fwdst), 0);
            chk("rst_exe_load", int'(exe_load), 0);
            chk("rst_wpcir", int'(wpcir), 1);
            chk("rst_stall_cnt", int'(stall_cnt), 0);
            chk("rst_fwd_cnt", int'(fwd_cnt), 0);
        end
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // add $3,$1,$2 ; sub $4,$3,$1 ; sub $5,$1,$3
        set_id(1, 2, 3, 1, 1, 0, 1, 0, 0); step();
        set_id(3, 1, 4, 1, 1, 0, 1, 0, 0); step();
        chk("t2_fwda_exe", int'(obs_fwda), 1);
        chk("t2_fwdb_reg", int'(obs_fwdb), 0);
        set_id(1, 3, 5, 1, 1, 0, 1, 0, 0); step();
        chk("t2_fwdb_mem", int'(obs_fwdb), 2);

        // lw $3,0($1) ; add $4,$3,$2 (held one cycle by the stall)
        set_id(1, 3, 3, 1, 0, 0, 1, 1, 0); step();
        set_id(3, 2, 4, 1, 1, 0, 1, 0, 0); step();
        chk("t3_exe_load", int'(obs_exe_load), 1);
        chk("t3_wpcir", int'(obs_wpcir), 0);
        step();
        chk("t3_stall_cnt", int'(obs_stall_cnt), 1);
        chk("t3_fwda_load", int'(obs_fwda), 3);
        chk("t3_no_2nd_stall", int'(obs_exe_load), 0);

        // add $3 ; sw $3,4($1) ; add $0 ; use of $0
        set_id(1, 2, 3, 1, 1, 0, 1, 0, 0); step();
        set_id(1, 3, 0, 1, 0, 1, 0, 0, 0); step();
        chk("t4_fwdst", int'(obs_fwdst), 1);
        chk("t4_fwdb", int'(obs_fwdb), 0);
        set_id(1, 2, 0, 1, 1, 0, 1, 0, 0); step();
        set_id(0, 0, 6, 1, 1, 1, 1, 0, 0); step();
        chk("t4_r0_a", int'(obs_fwda), 0);
        chk("t4_r0_b", int'(obs_fwdb), 0);
        chk("t4_r0_st", int'(obs_fwdst), 0);

        // Two producers of $3 in EX and MEM: EX wins.
        set_id(1, 2, 3, 1, 1, 0, 1, 0, 0); step();
        set_id(2, 1, 3, 1, 1, 0, 1, 0, 0); step();
        set_id(3, 3, 7, 1, 1, 0, 1, 0, 0); step();
        chk("t5_prio_a", int'(obs_fwda), 1);
        chk("t5_prio_b", int'(obs_fwdb), 1);

        // Taken branch colliding with a load-use stall.
        set_id(1, 3, 3, 1, 0, 0, 1, 1, 0); step();
        set_id(3, 2, 0, 1, 1, 0, 0, 0, 1); step();
        chk("t5_bt_stall", int'(obs_exe_load), 1);
        set_id(1, 2, 8, 1, 1, 0, 1, 0, 0); step();
        chk("t5_bt_nostall", int'(obs_exe_load), 0);
        chk("t5_bt_fwda", int'(obs_fwda), 0);
        chk("t5_bt_fwdb", int'(obs_fwdb), 0);

        // Random traffic over a small register window to provoke frequent hazards.
        for (int i = 0; i < 600; i++) begin
            bit bt;
            bt = ($urandom_range(7) == 0);
            set_id($urandom_range(3), $urandom_range(3), $urandom_range(3),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom) & ~bt, 1'($urandom), bt);
            step();
        end

        // lw $3,0($3) repeated: stalls every other cycle until the narrow counter saturates.
        for (int i = 0; i < 2 * (SMALL_MAX + 5); i++) begin
            set_id(3, 3, 3, 1, 0, 0, 1, 1, 0);
            step();
        end
        chk("sat_stall_s", int'(stall_cnt_s), SMALL_MAX);
        chk("sat_fwd_s", int'(fwd_cnt_s), SMALL_MAX);

        // Reset asserted mid-stall drops exe_load without a clock edge.
        set_id(1, 3, 3, 1, 0, 0, 1, 1, 0); step();
        set_id(3, 0, 4, 1, 0, 0, 1, 0, 0);
        #1;
        chk("mid_stall_pre", int'(exe_load), 1);
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_stall_exe_load", int'(exe_load), 0);
        chk("mid_stall_wpcir", int'(wpcir), 1);
        chk("mid_stall_cnt", int'(stall_cnt), 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        reset_model();

        // Recovery after reset.
        for (int i = 0; i < 40; i++) begin
            set_id($urandom_range(3), $urandom_range(3), $urandom_range(3),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
